// File: rtl/ring_contactor_sequencer.sv
// Ring contactor sequencer: break-before-make switching of eight contactors
// (A..H) towards a target closed set, with feedback/permit supervision.
// Optional build macro RING_FB_MONITOR_EN: supervise feedback against the
// coil commands while idle and fault on a persistent mismatch.
module ring_contactor_sequencer #(
    parameter int FB_TIMEOUT = 1000,
    parameter int SETTLE     = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [7:0] i_req_pattern,
    input  logic [7:0] i_permit,
    input  logic [7:0] i_fb,
    output logic [7:0] o_cmd,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault,
    output logic [2:0] o_fault_idx,
    input  logic       i_fault_clr
);

    typedef enum logic [2:0] {S_IDLE, S_OPEN, S_SETTLE, S_CLOSE, S_FAULT} state_t;

    localparam logic [15:0] P_TO  = FB_TIMEOUT[15:0];
    localparam logic [15:0] P_SET = SETTLE[15:0];

    state_t      r_state, w_state_nx;
    logic [7:0]  r_tgt, w_tgt_nx;
    logic [7:0]  r_cmd, w_cmd_nx;
    logic [7:0]  r_mask, w_mask_nx;     // bits opened by the current sequence
    logic [15:0] r_cnt, w_cnt_nx;
    logic [2:0]  r_bit, w_bit_nx;       // bit whose feedback is awaited
    logic        r_phase, w_phase_nx;   // 0: awaiting permit, 1: awaiting feedback
    logic        r_done, w_done_nx;
    logic        r_fault, w_fault_nx;
    logic [2:0]  r_fidx, w_fidx_nx;

    logic [15:0] w_cnt_inc;
    logic [7:0]  w_pdrop, w_pend, w_open_wait;
    logic [2:0]  w_k;
    logic        w_flt;
    logic [2:0]  w_flt_idx;

    // Lowest set bit of a vector (0 when empty).
    function automatic logic [2:0] f_low(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign w_cnt_inc   = r_cnt + 16'd1;
    assign w_pdrop     = r_cmd & ~i_permit;
    assign w_pend      = r_tgt & ~r_cmd;
    assign w_k         = f_low(w_pend);
    assign w_open_wait = i_fb & r_mask;

    // Next-state and next-register logic; faults override everything else.
    always_comb begin
        w_state_nx = r_state;
        w_tgt_nx   = r_tgt;
        w_cmd_nx   = r_cmd;
        w_mask_nx  = r_mask;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_phase_nx = r_phase;
        w_done_nx  = 1'b0;
        w_fault_nx = r_fault;
        w_fidx_nx  = r_fidx;
        w_flt      = 1'b0;
        w_flt_idx  = 3'd0;

        case (r_state)
            S_IDLE: begin
`ifdef RING_FB_MONITOR_EN
                if (i_fb != r_cmd) begin
                    if (w_cnt_inc == P_TO) begin
                        w_flt     = 1'b1;
                        w_flt_idx = f_low(i_fb ^ r_cmd);
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nx = 16'd0;
                end
`endif
                if (i_req_valid) begin
                    w_tgt_nx   = i_req_pattern;
                    w_cmd_nx   = r_cmd & i_req_pattern;
                    w_mask_nx  = r_cmd & ~i_req_pattern;
                    w_cnt_nx   = 16'd0;
                    w_state_nx = S_OPEN;
                end
            end
            S_OPEN: begin
                if (w_open_wait == 8'd0) begin
                    w_cnt_nx   = 16'd0;
                    w_phase_nx = 1'b0;
                    w_state_nx = (r_mask == 8'd0) ? S_CLOSE : S_SETTLE;
                end else if (w_cnt_inc == P_TO) begin
                    w_flt     = 1'b1;
                    w_flt_idx = f_low(w_open_wait);
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            S_SETTLE: begin
                if (w_cnt_inc == P_SET) begin
                    w_cnt_nx   = 16'd0;
                    w_phase_nx = 1'b0;
                    w_state_nx = S_CLOSE;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            S_CLOSE: begin
                if (!r_phase) begin
                    if (w_pend == 8'd0) begin
                        w_done_nx  = 1'b1;
                        w_cnt_nx   = 16'd0;
                        w_state_nx = S_IDLE;
                    end else if (i_permit[w_k]) begin
                        w_cmd_nx[w_k] = 1'b1;
                        w_bit_nx      = w_k;
                        w_phase_nx    = 1'b1;
                        w_cnt_nx      = 16'd0;
                    end else if (w_cnt_inc == P_TO) begin
                        w_flt     = 1'b1;
                        w_flt_idx = w_k;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    if (i_fb[r_bit]) begin
                        w_phase_nx = 1'b0;
                        w_cnt_nx   = 16'd0;
                    end else if (w_cnt_inc == P_TO) begin
                        w_flt     = 1'b1;
                        w_flt_idx = r_bit;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
            end
            S_FAULT: begin
                if (i_fault_clr) begin
                    w_fault_nx = 1'b0;
                    w_cnt_nx   = 16'd0;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // A commanded contactor losing its permit beats any other cause.
        if (w_pdrop != 8'd0) begin
            w_flt     = 1'b1;
            w_flt_idx = f_low(w_pdrop);
        end

        if (w_flt) begin
            w_state_nx = S_FAULT;
            w_cmd_nx   = 8'd0;
            w_fault_nx = 1'b1;
            w_fidx_nx  = w_flt_idx;
            w_cnt_nx   = 16'd0;
            w_phase_nx = 1'b0;
            w_done_nx  = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_tgt   <= 8'd0;
            r_cmd   <= 8'd0;
            r_mask  <= 8'd0;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_phase <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_fidx  <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_tgt   <= w_tgt_nx;
            r_cmd   <= w_cmd_nx;
            r_mask  <= w_mask_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_phase <= w_phase_nx;
            r_done  <= w_done_nx;
            r_fault <= w_fault_nx;
            r_fidx  <= w_fidx_nx;
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state == S_OPEN) || (r_state == S_SETTLE) || (r_state == S_CLOSE);
    assign o_cmd       = r_cmd;
    assign o_done      = r_done;
    assign o_fault     = r_fault;
    assign o_fault_idx = r_fidx;

endmodule

// File: tb/tb_ring_contactor_sequencer.sv
// Scoreboard bench for ring_contactor_sequencer: contactor environment with
// feedback lag, randomized requests with injected faults, and a monitor that
// checks completions, faults, close ordering and the dead-time gap.
module tb_ring_contactor_sequencer;

    localparam int TO  = 200;
    localparam int SET = 16;
    localparam int BUDGET = 4 * TO + 600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       fclr = 1'b0;
    logic [7:0] pat = 8'h00;
    logic [7:0] perm = 8'hFF;
    logic [7:0] fb = 8'h00;
    logic       ready, busy, done, fault;
    logic [7:0] cmd;
    logic [2:0] fidx;

    // environment: fb follows cmd three cycles late, with stuck overrides
    logic [7:0] p1 = 8'h00, p2 = 8'h00, p3 = 8'h00;
    logic [7:0] f0 = 8'h00, f1 = 8'h00;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         flt;
        logic [7:0] cmd;
        logic [2:0] idx;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] mcmd = 8'h00;   // reference model: closed set while idle
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    ring_contactor_sequencer #(.FB_TIMEOUT(TO), .SETTLE(SET)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready),
        .i_req_pattern(pat), .i_permit(perm), .i_fb(fb), .o_cmd(cmd),
        .o_busy(busy), .o_done(done), .o_fault(fault), .o_fault_idx(fidx),
        .i_fault_clr(fclr)
    );

    always @(posedge clk) begin
        #2;
        p3 = p2; p2 = p1; p1 = cmd;
        fb = (p3 | f1) & ~f0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int lowbit(input logic [7:0] v);
        int r;
        r = -1;
        for (int i = 7; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // monitor: pops scoreboard on done/fault, checks ordering and dead time
    logic [7:0] m_prev, m_open, gained, lost;
    bit m_armed, m_pf;
    int m_tf, m_last, cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (rst || !mon_en) begin
            m_prev = 8'h00; m_armed = 0; m_tf = -1; m_last = -1; m_pf = 0;
        end else begin
            chk("one_of_ready_busy_fault", int'(ready) + int'(busy) + int'(fault), 1);
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done cmd=%0h", cmd);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_kind", e.flt, 0);
                    chk("done_cmd", cmd, e.cmd);
                end
            end
            if (fault && !m_pf) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_fault idx=%0d", fidx);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("fault_kind", e.flt, 1);
                    chk("fault_idx", fidx, e.idx);
                    chk("fault_cmd_clear", cmd, 0);
                end
            end
            gained = cmd & ~m_prev;
            lost   = m_prev & ~cmd;
            if (lost != 0 && busy) begin
                m_open = lost; m_armed = 1; m_tf = -1;
            end
            if (m_armed && m_tf < 0 && (fb & m_open) == 0) m_tf = cyc;
            if (gained != 0) begin
                chk("close_single_bit", $countones(gained), 1);
                chk("close_ascending", lowbit(gained) > m_last, 1);
                m_last = lowbit(gained);
                if (m_armed) begin
                    // fb seen open, SET cycles of dead time, one cycle to close
                    chk("settle_gap", (m_tf < 0) ? 0 : cyc - m_tf, SET + 2);
                    m_armed = 0;
                end
            end
            if (ready || fault) begin
                m_armed = 0; m_last = -1;
            end
            m_pf = fault;
            m_prev = cmd;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [7:0] p);
        tick();
        req_valid = 1'b1; pat = p;
        tick();
        req_valid = 1'b0; pat = $urandom;
    endtask

    task automatic push(input bit flt, input logic [7:0] c, input int k);
        exp_t e;
        e.flt = flt; e.cmd = c; e.idx = 3'(k);
        sbq.push_back(e);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!ready && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) begin
            checks++; failures++;
            $display("FAIL idle_timeout waited=%0d needed<%0d", n, BUDGET);
        end
    endtask

    task automatic fault_clear();
        int n;
        n = 0;
        while (!fault && n < BUDGET) begin tick(); n++; end
        chk("fault_reached", fault, 1);
        f0 = 8'h00; f1 = 8'h00; perm = 8'hFF;
        tick();
        fclr = 1'b1;
        tick();
        fclr = 1'b0;
        chk("clr_ready", ready, 1);
        chk("clr_fault", fault, 0);
        mcmd = 8'h00;
        repeat (5) tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_cmd", cmd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_idx", fidx, 0);
        rst = 1'b0;
        tick();
        chk("rst_ready", ready, 1);
        mon_en = 1'b1;

        // 0x05 then 0x0A: break-before-make with dead time
        push(0, 8'h05, 0); issue(8'h05); wait_idle(n); mcmd = 8'h05;
        chk("seq05_cmd", cmd, 8'h05);
        push(0, 8'h0A, 0); issue(8'h0A); wait_idle(n); mcmd = 8'h0A;
        chk("seq0A_cmd", cmd, 8'h0A);
        // identical target completes quickly without touching cmd
        push(0, 8'h0A, 0); issue(8'h0A); wait_idle(n);
        chk("same_latency_le10", n <= 10, 1);

        // permit drops while idle, single and multiple
        push(0, 8'h03, 0); issue(8'h03); wait_idle(n);
        push(1, 8'h00, 1); perm = 8'hFD; fault_clear();
        push(0, 8'h07, 0); issue(8'h07); wait_idle(n);
        push(1, 8'h00, 1); perm = 8'hF9; fault_clear();

        // feedback stuck open on close
        push(1, 8'h00, 0); f0 = 8'h01; issue(8'h01); fault_clear();

        // idle feedback mismatch
        tick();
        f1 = 8'h10;
`ifdef RING_FB_MONITOR_EN
        push(1, 8'h00, 4);
        fault_clear();
`else
        repeat (TO + 20) tick();
        chk("mon_off_nofault", fault, 0);
        f1 = 8'h00;
        repeat (5) tick();
`endif

        // reset in the middle of CLOSE
        perm = 8'h7F; issue(8'h81);
        repeat (20) tick();
        chk("pre_rst_cmd", cmd, 8'h01);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("midrst_cmd", cmd, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0; perm = 8'hFF; mcmd = 8'h00;
        repeat (5) tick();

        // randomized requests against the reference outcome
        for (int it = 0; it < 40; it++) begin
            logic [7:0] p, cand;
            int sc, k;
            p = 8'($urandom);
            sc = $urandom_range(0, 9);
            if (sc == 9) p = mcmd;
            cand = 8'h00;
            if (sc == 6 || sc == 8) cand = p & ~mcmd;
            if (sc == 7) cand = mcmd & ~p;
            if (sc >= 6 && sc <= 8 && cand == 0) sc = 0;
            k = 0;
            if (sc >= 6 && sc <= 8) begin
                k = $urandom_range(0, 7);
                while (!cand[k]) k = $urandom_range(0, 7);
            end
            if (sc == 6) f0[k] = 1'b1;
            if (sc == 7) f1[k] = 1'b1;
            if (sc == 8) perm[k] = 1'b0;
            if (sc >= 6 && sc <= 8) begin
                push(1, 8'h00, k);
                issue(p);
                fault_clear();
            end else begin
                push(0, p, 0);
                issue(p);
                wait_idle(n);
                if (sc == 9) chk("rand_same_latency_le10", n <= 10, 1);
                mcmd = p;
            end
        end

        repeat (10) tick();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
